// File: rtl/toy_bus_mem_initiator.sv
// toy_bus_mem_initiator: core-to-ToyBus initiator with registered request stage and credit-protected read response FIFO
module toy_bus_mem_initiator #(
    parameter logic [3:0] NODE_ID   = 4'd1,
    parameter int         RSP_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in0_req_vld,
    output logic         in0_req_rdy,
    input  logic [31:0]  in0_req_addr,
    input  logic         in0_req_wr_en,
    input  logic [255:0] in0_req_wr_data,
    input  logic [31:0]  in0_req_byte_en,
    input  logic [3:0]   in0_req_tgt_id,
    input  logic [9:0]   in0_req_sideband,
    output logic         in0_rsp_vld,
    input  logic         in0_rsp_rdy,
    output logic [255:0] in0_rsp_data,
    output logic [9:0]   in0_rsp_sideband,
    output logic         out0_req_vld,
    input  logic         out0_req_rdy,
    output logic [31:0]  out0_req_addr,
    output logic [31:0]  out0_req_strb,
    output logic [255:0] out0_req_data,
    output logic         out0_req_opcode,
    output logic [3:0]   out0_req_src_id,
    output logic [3:0]   out0_req_tgt_id,
    output logic [9:0]   out0_req_sideband,
    input  logic         out0_ack_vld,
    output logic         out0_ack_rdy,
    input  logic         out0_ack_opcode,
    input  logic [255:0] out0_ack_data,
    input  logic [9:0]   out0_ack_sideband,
    input  logic [3:0]   out0_ack_src_id,
    input  logic [3:0]   out0_ack_tgt_id,
    output logic [4:0]   rd_outstanding,
    output logic         err_tgt_mismatch
);
    localparam int AW = $clog2(RSP_DEPTH);
    logic           free, acc, rd_acc, tgt_ok, push, pop, drop, unused;
    logic [AW:0]    wp, rp;
    logic [265:0]   mem [RSP_DEPTH];
    logic [265:0]   head;
    assign free             = !out0_req_vld | out0_req_rdy;
    assign in0_req_rdy      = !rst & free & (in0_req_wr_en | (rd_outstanding < 5'(RSP_DEPTH)));
    assign acc              = in0_req_vld & in0_req_rdy;
    assign rd_acc           = acc & !in0_req_wr_en;
    assign out0_req_src_id  = NODE_ID;
    assign out0_ack_rdy     = 1'b1;
    assign tgt_ok           = out0_ack_tgt_id == NODE_ID;
    // an ack with no read in flight is never trusted, even if addressed to us
    assign push             = out0_ack_vld & tgt_ok & (rd_outstanding != 5'd0);
    assign pop              = in0_rsp_vld & in0_rsp_rdy;
    assign drop             = out0_ack_vld & !tgt_ok & (rd_outstanding > {4'b0, pop});
    assign in0_rsp_vld      = wp != rp;
    assign head             = mem[rp[AW-1:0]];
    assign in0_rsp_data     = head[265:10];
    assign in0_rsp_sideband = head[9:0];
    assign unused           = ^{out0_ack_opcode, out0_ack_src_id};
    always_ff @(posedge clk) begin
        if (rst) begin
            out0_req_vld     <= 1'b0;
            wp               <= '0;
            rp               <= '0;
            rd_outstanding   <= '0;
            err_tgt_mismatch <= 1'b0;
        end else begin
            out0_req_vld     <= acc | (out0_req_vld & !out0_req_rdy);
            wp               <= push ? wp + 1'b1 : wp;
            rp               <= pop ? rp + 1'b1 : rp;
            rd_outstanding   <= rd_outstanding + 5'(rd_acc) - 5'(pop & (rd_outstanding != 5'd0)) - 5'(drop);
            err_tgt_mismatch <= err_tgt_mismatch | (out0_ack_vld & !push);
        end
    end
    always_ff @(posedge clk) begin
        if (acc) begin
            out0_req_addr     <= in0_req_addr;
            out0_req_strb     <= in0_req_byte_en;
            out0_req_data     <= in0_req_wr_data;
            out0_req_opcode   <= in0_req_wr_en;
            out0_req_tgt_id   <= in0_req_tgt_id;
            out0_req_sideband <= in0_req_sideband;
        end
        if (push) mem[wp[AW-1:0]] <= {out0_ack_data, out0_ack_sideband};
    end
endmodule

// File: tb/tb_toy_bus_mem_initiator.sv
// tb_toy_bus_mem_initiator: vector table, directed corner sequences and random traffic against a queue-based model
module tb_toy_bus_mem_initiator;
    localparam logic [3:0] NODE  = 4'd1;
    localparam int         DEPTH = 4;
    logic         clk = 1'b0, rst = 1'b1;
    logic         in0_req_vld, in0_req_rdy, in0_req_wr_en;
    logic [31:0]  in0_req_addr, in0_req_byte_en;
    logic [255:0] in0_req_wr_data;
    logic [3:0]   in0_req_tgt_id;
    logic [9:0]   in0_req_sideband;
    logic         in0_rsp_vld, in0_rsp_rdy;
    logic [255:0] in0_rsp_data;
    logic [9:0]   in0_rsp_sideband;
    logic         out0_req_vld, out0_req_rdy, out0_req_opcode;
    logic [31:0]  out0_req_addr, out0_req_strb;
    logic [255:0] out0_req_data;
    logic [3:0]   out0_req_src_id, out0_req_tgt_id;
    logic [9:0]   out0_req_sideband;
    logic         out0_ack_vld = 1'b0, out0_ack_rdy, out0_ack_opcode = 1'b0;
    logic [255:0] out0_ack_data = '0;
    logic [9:0]   out0_ack_sideband = '0;
    logic [3:0]   out0_ack_src_id = '0, out0_ack_tgt_id = '0;
    logic [4:0]   rd_outstanding;
    logic         err_tgt_mismatch;
    logic         inject = 1'b0, bad_tgt = 1'b0;

    always #5 clk = ~clk;

    toy_bus_mem_initiator #(.NODE_ID(NODE), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in0_req_vld(in0_req_vld), .in0_req_rdy(in0_req_rdy), .in0_req_addr(in0_req_addr),
        .in0_req_wr_en(in0_req_wr_en), .in0_req_wr_data(in0_req_wr_data), .in0_req_byte_en(in0_req_byte_en),
        .in0_req_tgt_id(in0_req_tgt_id), .in0_req_sideband(in0_req_sideband),
        .in0_rsp_vld(in0_rsp_vld), .in0_rsp_rdy(in0_rsp_rdy), .in0_rsp_data(in0_rsp_data),
        .in0_rsp_sideband(in0_rsp_sideband),
        .out0_req_vld(out0_req_vld), .out0_req_rdy(out0_req_rdy), .out0_req_addr(out0_req_addr),
        .out0_req_strb(out0_req_strb), .out0_req_data(out0_req_data), .out0_req_opcode(out0_req_opcode),
        .out0_req_src_id(out0_req_src_id), .out0_req_tgt_id(out0_req_tgt_id),
        .out0_req_sideband(out0_req_sideband),
        .out0_ack_vld(out0_ack_vld), .out0_ack_rdy(out0_ack_rdy), .out0_ack_opcode(out0_ack_opcode),
        .out0_ack_data(out0_ack_data), .out0_ack_sideband(out0_ack_sideband),
        .out0_ack_src_id(out0_ack_src_id), .out0_ack_tgt_id(out0_ack_tgt_id),
        .rd_outstanding(rd_outstanding), .err_tgt_mismatch(err_tgt_mismatch)
    );

    // slave partner: acks each read one cycle after its handshake, echoing the sideband
    always @(posedge clk) begin
        out0_ack_vld      <= (out0_req_vld & out0_req_rdy & !out0_req_opcode) | inject;
        out0_ack_data     <= {8{out0_req_addr ^ 32'hA5A5A5A5}};
        out0_ack_sideband <= out0_req_sideband;
        out0_ack_tgt_id   <= bad_tgt ? out0_req_src_id ^ 4'h8 : out0_req_src_id;
        out0_ack_src_id   <= out0_req_tgt_id;
        out0_ack_opcode   <= 1'b0;
    end

    typedef struct packed {
        logic [31:0] addr; logic [31:0] strb; logic [255:0] data;
        logic op; logic [3:0] tgt; logic [9:0] sb;
    } req_t;
    typedef struct {
        bit wr; logic [31:0] addr; logic [9:0] sb; bit exp_rsp; logic [31:0] exp_word;
    } vec_t;

    req_t         mq[$];
    logic [265:0] rq[$];
    int           mcnt = 0;
    bit           merr = 0;
    int           checks = 0, errors = 0;

    task automatic chk(string n, logic [399:0] a, logic [399:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    task automatic idle();
        in0_req_vld = 0; in0_req_wr_en = 0; in0_rsp_rdy = 0; out0_req_rdy = 1;
        inject = 0; bad_tgt = 0;
    endtask

    task automatic set_req(bit wr, logic [31:0] a, logic [9:0] sb);
        in0_req_vld = 1; in0_req_wr_en = wr; in0_req_addr = a; in0_req_sideband = sb;
        in0_req_byte_en = $urandom; in0_req_tgt_id = 4'($urandom);
        for (int w = 0; w < 8; w++) in0_req_wr_data[w*32 +: 32] = $urandom;
    endtask

    // inputs are set at the negedge; check outputs against the model, then advance the model over the posedge
    task automatic cyc();
        bit exp_rdy, pop, acc, hs, dec;
        req_t got;
        #1;
        exp_rdy = !rst && (mq.size() == 0 || out0_req_rdy) && (in0_req_wr_en || mcnt < DEPTH);
        chk("req_rdy", 400'(in0_req_rdy), 400'(exp_rdy));
        chk("req_vld", 400'(out0_req_vld), 400'(mq.size() != 0));
        if (mq.size() != 0) begin
            got = {out0_req_addr, out0_req_strb, out0_req_data, out0_req_opcode, out0_req_tgt_id, out0_req_sideband};
            chk("req_fields", 400'(got), 400'(mq[0]));
            chk("req_src_id", 400'(out0_req_src_id), 400'(NODE));
        end
        chk("ack_rdy", 400'(out0_ack_rdy), 400'(1));
        chk("rsp_vld", 400'(in0_rsp_vld), 400'(rq.size() != 0));
        if (rq.size() != 0) chk("rsp_data", 400'({in0_rsp_data, in0_rsp_sideband}), 400'(rq[0]));
        chk("outstanding", 400'(rd_outstanding), 400'(mcnt));
        chk("err_flag", 400'(err_tgt_mismatch), 400'(merr));
        if (rst) begin
            mq.delete(); rq.delete(); mcnt = 0; merr = 0;
        end else begin
            pop = rq.size() != 0 && in0_rsp_rdy;
            acc = in0_req_vld && exp_rdy;
            hs  = mq.size() != 0 && out0_req_rdy;
            dec = 0;
            if (out0_ack_vld) begin
                if (out0_ack_tgt_id == NODE && mcnt != 0) rq.push_back({out0_ack_data, out0_ack_sideband});
                else begin
                    merr = 1;
                    dec  = out0_ack_tgt_id != NODE && mcnt > int'(pop);
                end
            end
            mcnt = mcnt + int'(acc && !in0_req_wr_en) - int'(pop && mcnt != 0) - int'(dec);
            if (pop) void'(rq.pop_front());
            if (hs) void'(mq.pop_front());
            if (acc) mq.push_back({in0_req_addr, in0_req_byte_en, in0_req_wr_data, in0_req_wr_en,
                                   in0_req_tgt_id, in0_req_sideband});
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[5];
        int   acc_n;
        tbl[0] = '{1'b1, 32'h0000_0040, 10'h001, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h0000_0020, 10'h155, 1'b1, 32'hA5A5_A585};
        tbl[2] = '{1'b0, 32'h0000_0100, 10'h3FF, 1'b1, 32'hA5A5_A4A5};
        tbl[3] = '{1'b1, 32'h0000_1234, 10'h0F0, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 32'hFFFF_FFE0, 10'h2AA, 1'b1, 32'h5A5A_5A45};
        idle();
        in0_req_addr = '0; in0_req_byte_en = '0; in0_req_wr_data = '0; in0_req_tgt_id = '0; in0_req_sideband = '0;
        rst = 1;
        @(negedge clk);
        in0_req_vld = 1; in0_req_wr_en = 1;
        cyc(); cyc();
        chk("rst_req_rdy", 400'(in0_req_rdy), 400'(0));
        chk("rst_req_vld", 400'(out0_req_vld), 400'(0));
        chk("rst_rsp_vld", 400'(in0_rsp_vld), 400'(0));
        chk("rst_outstanding", 400'(rd_outstanding), 400'(0));
        chk("rst_err", 400'(err_tgt_mismatch), 400'(0));
        rst = 0; in0_req_vld = 0;
        cyc();

        for (int i = 0; i < 5; i++) begin
            set_req(tbl[i].wr, tbl[i].addr, tbl[i].sb);
            if (i == 0) in0_req_byte_en = '1;
            cyc();
            in0_req_vld = 0;
            chk("t_vld_on", 400'(out0_req_vld), 400'(1));
            chk("t_opcode", 400'(out0_req_opcode), 400'(tbl[i].wr));
            chk("t_addr", 400'(out0_req_addr), 400'(tbl[i].addr));
            cyc();
            chk("t_vld_off", 400'(out0_req_vld), 400'(0));
            cyc();
            chk("t_rsp_vld", 400'(in0_rsp_vld), 400'(tbl[i].exp_rsp));
            chk("t_outstanding", 400'(rd_outstanding), 400'(tbl[i].exp_rsp));
            if (tbl[i].exp_rsp)
                chk("t_rsp_data", 400'({in0_rsp_data, in0_rsp_sideband}), 400'({{8{tbl[i].exp_word}}, tbl[i].sb}));
            in0_rsp_rdy = 1;
            cyc();
            in0_rsp_rdy = 0;
            chk("t_outstanding_pop", 400'(rd_outstanding), 400'(0));
            chk("t_rsp_empty", 400'(in0_rsp_vld), 400'(0));
        end

        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(0, 32'h1000 + 32'(i * 32), 10'(i));
            #1 acc_n += int'(in0_req_rdy);
            cyc();
        end
        chk("credit_accepts", 400'(acc_n), 400'(4));
        in0_req_wr_en = 1;
        #1 chk("write_at_credit_limit", 400'(in0_req_rdy), 400'(1));
        cyc();
        in0_req_vld = 0;
        cyc(); cyc(); cyc();
        chk("full_outstanding", 400'(rd_outstanding), 400'(4));
        in0_rsp_rdy = 1;
        cyc();
        in0_rsp_rdy = 0;
        set_req(0, 32'h2000, 10'h0AA);
        #1 chk("read_after_pop", 400'(in0_req_rdy), 400'(1));
        cyc();
        #1 chk("limit_again", 400'(in0_req_rdy), 400'(0));
        cyc();
        in0_req_vld = 0;
        cyc(); cyc();
        chk("full_fifo_vld", 400'(in0_rsp_vld), 400'(1));
        in0_rsp_rdy = 1;
        for (int i = 0; i < 10; i++) begin
            set_req(0, 32'h3000 + 32'(i * 32), 10'(i + 16));
            cyc();
        end
        in0_req_vld = 0;
        for (int i = 0; i < 8; i++) cyc();
        chk("stream_drained", 400'(rd_outstanding), 400'(0));
        in0_rsp_rdy = 0;

        out0_req_rdy = 0;
        set_req(1, 32'hCAFE_0000, 10'h2AA);
        cyc();
        set_req(1, 32'hBEEF_0000, 10'h155);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_rdy", 400'(in0_req_rdy), 400'(0));
            chk("stall_addr", 400'(out0_req_addr), 400'(32'hCAFE_0000));
            chk("stall_vld", 400'(out0_req_vld), 400'(1));
            cyc();
        end
        out0_req_rdy = 1;
        cyc();
        in0_req_vld = 0;
        chk("stall_next_addr", 400'(out0_req_addr), 400'(32'hBEEF_0000));
        cyc();
        chk("stall_done", 400'(out0_req_vld), 400'(0));

        chk("err_before", 400'(err_tgt_mismatch), 400'(0));
        bad_tgt = 1;
        set_req(0, 32'h0300, 10'h011);
        cyc();
        in0_req_vld = 0;
        cyc();
        bad_tgt = 0;
        cyc();
        chk("mismatch_err", 400'(err_tgt_mismatch), 400'(1));
        chk("mismatch_credit", 400'(rd_outstanding), 400'(0));
        chk("mismatch_no_push", 400'(in0_rsp_vld), 400'(0));
        cyc(); cyc(); cyc();
        chk("mismatch_sticky", 400'(err_tgt_mismatch), 400'(1));

        rst = 1;
        cyc();
        rst = 0;
        cyc();
        chk("err_cleared", 400'(err_tgt_mismatch), 400'(0));
        inject = 1;
        cyc();
        inject = 0;
        cyc();
        chk("stray_ack_err", 400'(err_tgt_mismatch), 400'(1));
        chk("stray_ack_no_push", 400'(in0_rsp_vld), 400'(0));
        chk("stray_ack_credit", 400'(rd_outstanding), 400'(0));

        rst = 1; cyc(); rst = 0; cyc();
        for (int i = 0; i < 3; i++) begin
            set_req(0, 32'h4000 + 32'(i * 32), 10'(i));
            cyc();
        end
        rst = 1;
        cyc();
        chk("midrst_req_vld", 400'(out0_req_vld), 400'(0));
        chk("midrst_rsp_vld", 400'(in0_rsp_vld), 400'(0));
        chk("midrst_outstanding", 400'(rd_outstanding), 400'(0));
        chk("midrst_err", 400'(err_tgt_mismatch), 400'(0));
        chk("midrst_req_rdy", 400'(in0_req_rdy), 400'(0));
        rst = 0; in0_req_vld = 0;
        cyc(); cyc(); cyc();

        rst = 1; cyc(); rst = 0; cyc();
        for (int i = 0; i < 2000; i++) begin
            rst = $urandom_range(0, 299) == 0;
            if ($urandom_range(0, 1) == 1) set_req($urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFE0, 10'($urandom));
            else in0_req_vld = 0;
            out0_req_rdy = $urandom_range(0, 9) < 7;
            in0_rsp_rdy  = $urandom_range(0, 9) < 5;
            bad_tgt      = $urandom_range(0, 19) == 0;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
